// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle controller, ALU control and datapath:
// FSM states, opcodes, ALU operand selects and the packed control vector.
package control_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        ILLEGAL   = 4'd10
    } stateT;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_SD    = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH1 = 2'b11;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       pcSource;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regWrite;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       illegal;
    } ctrlT;

    localparam ctrlT CTRL_NONE = '0;

    // States that hold their memory request until memReady is seen.
    function automatic logic isWaitState(input stateT s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_output_decode.sv
// Combinational map from controller state (plus memory ready, for the
// Mealy fetch strobes) to the datapath control vector.
module multicycle_output_decode
    import control_pkg::*;
(
    input  stateT state,
    input  logic  memReady,
    output ctrlT  ctrl
);

    always_comb begin
        ctrl = CTRL_NONE;
        case (state)
            FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.iorD     = 1'b0;
                ctrl.aluSrcA  = SRCA_PC;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.pcSource = 1'b0;
                ctrl.irWrite  = memReady;
                ctrl.pcWrite  = memReady;
            end
            DECODE: begin
                ctrl.aluSrcA = SRCA_OLDPC;
                ctrl.aluSrcB = SRCB_IMMSH1;
                ctrl.aluOp   = ALUOP_ADD;
            end
            MEM_ADDR: begin
                ctrl.aluSrcA = SRCA_RS1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            MEM_READ: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            MEM_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            EXECUTE: begin
                ctrl.aluSrcA = SRCA_RS1;
                ctrl.aluSrcB = SRCB_RS2;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            ALU_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = 1'b0;
            end
            BRANCH: begin
                ctrl.aluSrcA     = SRCA_RS1;
                ctrl.aluSrcB     = SRCB_RS2;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = 1'b1;
            end
            ILLEGAL: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller (R-type, ld, sd, beq) with memory handshake.
// Optional MCC_PERF_EN adds retired-instruction and stall counters.
module multicycle_control
    import control_pkg::*;
#(
`ifdef MCC_PERF_EN
    parameter int CNT_WIDTH    = 32,
`endif
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clockInput,
    input  logic       resetInput,
    input  logic [6:0] opcodeInput,
    input  logic       memReadyInput,
    output logic       pcWriteOutput,
    output logic       pcWriteCondOutput,
    output logic       pcSourceOutput,
    output logic       iorDOutput,
    output logic       memReadOutput,
    output logic       memWriteOutput,
    output logic       irWriteOutput,
    output logic       memToRegOutput,
    output logic       regWriteOutput,
    output logic [1:0] aluSrcAOutput,
    output logic [1:0] aluSrcBOutput,
    output logic [1:0] aluOpOutput,
    output logic       illegalOutput,
`ifdef MCC_PERF_EN
    output logic [CNT_WIDTH-1:0] retiredOutput,
    output logic [CNT_WIDTH-1:0] stallOutput,
`endif
    output logic [3:0] stateOutput
);

    stateT state;
    stateT stateNext;
    ctrlT  ctrl;

    always_ff @(posedge clockInput or posedge resetInput) begin
        if (resetInput) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: stateNext = FETCH;
            FETCH: begin
                if (memReadyInput) stateNext = DECODE;
            end
            DECODE: begin
                case (opcodeInput)
                    OPC_LD, OPC_SD: stateNext = MEM_ADDR;
                    OPC_RTYPE:      stateNext = EXECUTE;
                    OPC_BEQ:        stateNext = BRANCH;
                    default:        stateNext = ILLEGAL;
                endcase
            end
            MEM_ADDR: begin
                stateNext = (opcodeInput == OPC_SD) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                if (memReadyInput) stateNext = MEM_WB;
            end
            MEM_WB: stateNext = FETCH;
            MEM_WRITE: begin
                if (memReadyInput) stateNext = FETCH;
            end
            EXECUTE: stateNext = ALU_WB;
            ALU_WB:  stateNext = FETCH;
            BRANCH:  stateNext = FETCH;
            ILLEGAL: stateNext = ILLEGAL_HALT ? ILLEGAL : FETCH;
            default: stateNext = FETCH;
        endcase
    end

    multicycle_output_decode u_decode (
        .state    (state),
        .memReady (memReadyInput),
        .ctrl     (ctrl)
    );

    assign pcWriteOutput     = ctrl.pcWrite;
    assign pcWriteCondOutput = ctrl.pcWriteCond;
    assign pcSourceOutput    = ctrl.pcSource;
    assign iorDOutput        = ctrl.iorD;
    assign memReadOutput     = ctrl.memRead;
    assign memWriteOutput    = ctrl.memWrite;
    assign irWriteOutput     = ctrl.irWrite;
    assign memToRegOutput    = ctrl.memToReg;
    assign regWriteOutput    = ctrl.regWrite;
    assign aluSrcAOutput     = ctrl.aluSrcA;
    assign aluSrcBOutput     = ctrl.aluSrcB;
    assign aluOpOutput       = ctrl.aluOp;
    assign illegalOutput     = ctrl.illegal;
    assign stateOutput       = state;

`ifdef MCC_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic retireEvent;
    logic stallEvent;

    // A store retires on the cycle its write is accepted, not on entry.
    assign retireEvent = (state == MEM_WB) || (state == ALU_WB) ||
                         (state == BRANCH) ||
                         ((state == MEM_WRITE) && memReadyInput);
    assign stallEvent  = isWaitState(state) && !memReadyInput;

    always_ff @(posedge clockInput or posedge resetInput) begin
        if (resetInput) begin
            retiredOutput <= '0;
            stallOutput   <= '0;
        end else begin
            if (retireEvent) retiredOutput <= retiredOutput + CNT_ONE;
            if (stallEvent)  stallOutput   <= stallOutput + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of instructions with
// memory wait patterns, a per-cycle scoreboard, plus reset and illegal cases.
module tb_multicycle_control;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_FETCH = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MADDR = 4'd3;
    localparam logic [3:0] S_MREAD = 4'd4;
    localparam logic [3:0] S_MWB = 4'd5;
    localparam logic [3:0] S_MWRITE = 4'd6;
    localparam logic [3:0] S_EXEC = 4'd7;
    localparam logic [3:0] S_ALUWB = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ILLEGAL = 4'd10;

    logic clk = 1'b0;
    logic rst;
    logic [6:0] opcode;
    logic ready;

    logic pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite;
    logic irWrite, memToReg, regWrite, illegal;
    logic [1:0] aluSrcA, aluSrcB, aluOp;
    logic [3:0] stateOut;

    logic zPcWrite, zPcWriteCond, zPcSource, zIorD, zMemRead, zMemWrite;
    logic zIrWrite, zMemToReg, zRegWrite, zIllegal;
    logic [1:0] zAluSrcA, zAluSrcB, zAluOp;
    logic [3:0] zStateOut;

`ifdef MCC_PERF_EN
    logic [31:0] retired, stall, zRetired, zStall;
`endif

    always #5 clk = ~clk;

    multicycle_control #(.ILLEGAL_HALT(1'b1)) dut (
        .clockInput(clk), .resetInput(rst), .opcodeInput(opcode),
        .memReadyInput(ready), .pcWriteOutput(pcWrite),
        .pcWriteCondOutput(pcWriteCond), .pcSourceOutput(pcSource),
        .iorDOutput(iorD), .memReadOutput(memRead),
        .memWriteOutput(memWrite), .irWriteOutput(irWrite),
        .memToRegOutput(memToReg), .regWriteOutput(regWrite),
        .aluSrcAOutput(aluSrcA), .aluSrcBOutput(aluSrcB),
        .aluOpOutput(aluOp), .illegalOutput(illegal),
`ifdef MCC_PERF_EN
        .retiredOutput(retired), .stallOutput(stall),
`endif
        .stateOutput(stateOut)
    );

    multicycle_control #(.ILLEGAL_HALT(1'b0)) dut0 (
        .clockInput(clk), .resetInput(rst), .opcodeInput(opcode),
        .memReadyInput(ready), .pcWriteOutput(zPcWrite),
        .pcWriteCondOutput(zPcWriteCond), .pcSourceOutput(zPcSource),
        .iorDOutput(zIorD), .memReadOutput(zMemRead),
        .memWriteOutput(zMemWrite), .irWriteOutput(zIrWrite),
        .memToRegOutput(zMemToReg), .regWriteOutput(zRegWrite),
        .aluSrcAOutput(zAluSrcA), .aluSrcBOutput(zAluSrcB),
        .aluOpOutput(zAluOp), .illegalOutput(zIllegal),
`ifdef MCC_PERF_EN
        .retiredOutput(zRetired), .stallOutput(zStall),
`endif
        .stateOutput(zStateOut)
    );

    logic [19:0] actVec;
    assign actVec = {stateOut, pcWrite, pcWriteCond, pcSource, iorD,
                     memRead, memWrite, irWrite, memToReg, regWrite,
                     aluSrcA, aluSrcB, aluOp, illegal};

    int nChecks = 0;
    int nFails = 0;
    logic [19:0] sbq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Expected control vector per state, written from the state table.
    function automatic logic [19:0] expVec(input logic [3:0] s,
                                           input logic r);
        logic pw, pwc, ps, io, mr, mw, ir, m2r, rw, il;
        logic [1:0] sa, sb, op;
        {pw, pwc, ps, io, mr, mw, ir, m2r, rw, il} = '0;
        sa = 2'b00; sb = 2'b00; op = 2'b00;
        case (s)
            S_FETCH:   begin mr = 1; sb = 2'b01; ir = r; pw = r; end
            S_DECODE:  begin sa = 2'b10; sb = 2'b11; end
            S_MADDR:   begin sa = 2'b01; sb = 2'b10; end
            S_MREAD:   begin mr = 1; io = 1; end
            S_MWB:     begin rw = 1; m2r = 1; end
            S_MWRITE:  begin mw = 1; io = 1; end
            S_EXEC:    begin sa = 2'b01; op = 2'b10; end
            S_ALUWB:   begin rw = 1; end
            S_BRANCH:  begin sa = 2'b01; op = 2'b01; pwc = 1; ps = 1; end
            S_ILLEGAL: begin il = 1; end
            default:   ;
        endcase
        return {s, pw, pwc, ps, io, mr, mw, ir, m2r, rw, sa, sb, op, il};
    endfunction

    always @(negedge clk) begin
        if (sbq.size() > 0) chk("ctrlVec", 32'(actVec), 32'(sbq.pop_front()));
    end

    typedef struct {
        logic [6:0] opc;
        int fWait;
        int mWait;
        int cyc;
        int rw;
        int mw;
        int mr;
    } vecT;

    vecT tbl[8];

    function automatic logic rnd();
        return $urandom_range(0, 1) != 0;
    endfunction

    task automatic runInstr(input vecT v);
        logic [3:0] seqS[$];
        logic seqR[$];
        int cyc = 0;
        int rw = 0;
        int mw = 0;
        int mr = 0;
        logic isWait;
`ifdef MCC_PERF_EN
        logic [31:0] ret0 = 0;
        logic [31:0] st0 = 0;
`endif
        opcode = v.opc;
        for (int k = 0; k < v.fWait; k++) begin
            seqS.push_back(S_FETCH); seqR.push_back(1'b0);
        end
        seqS.push_back(S_FETCH); seqR.push_back(1'b1);
        seqS.push_back(S_DECODE); seqR.push_back(rnd());
        case (v.opc)
            7'b0110011: begin
                seqS.push_back(S_EXEC); seqR.push_back(rnd());
                seqS.push_back(S_ALUWB); seqR.push_back(rnd());
            end
            7'b0000011: begin
                seqS.push_back(S_MADDR); seqR.push_back(rnd());
                for (int k = 0; k < v.mWait; k++) begin
                    seqS.push_back(S_MREAD); seqR.push_back(1'b0);
                end
                seqS.push_back(S_MREAD); seqR.push_back(1'b1);
                seqS.push_back(S_MWB); seqR.push_back(rnd());
            end
            7'b0100011: begin
                seqS.push_back(S_MADDR); seqR.push_back(rnd());
                for (int k = 0; k < v.mWait; k++) begin
                    seqS.push_back(S_MWRITE); seqR.push_back(1'b0);
                end
                seqS.push_back(S_MWRITE); seqR.push_back(1'b1);
            end
            default: begin
                seqS.push_back(S_BRANCH); seqR.push_back(rnd());
            end
        endcase
        for (int i = 0; i < seqS.size(); i++) begin
            #1;
`ifdef MCC_PERF_EN
            if (i == 0) begin ret0 = retired; st0 = stall; end
`endif
            ready = seqR[i];
            sbq.push_back(expVec(seqS[i], seqR[i]));
            @(negedge clk);
            isWait = (stateOut == S_FETCH) || (stateOut == S_MREAD) ||
                     (stateOut == S_MWRITE);
            if (!(isWait && !ready)) cyc++;
            rw += int'(regWrite);
            mw += int'(memWrite);
            mr += int'(memRead);
            chk("rdWrExcl", 32'(memRead & memWrite), 32'd0);
            @(posedge clk);
        end
        #1;
        chk("latency", cyc, v.cyc);
        chk("regWriteCyc", rw, v.rw);
        chk("memWriteCyc", mw, v.mw);
        chk("memReadCyc", mr, v.mr);
`ifdef MCC_PERF_EN
        chk("retiredDelta", retired - ret0, 32'd1);
        chk("stallDelta", stall - st0, 32'(v.fWait + v.mWait));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{7'b0110011, 0, 0, 4, 1, 0, 1};
        tbl[1] = '{7'b0000011, 0, 3, 5, 1, 0, 5};
        tbl[2] = '{7'b0100011, 0, 0, 4, 0, 1, 1};
        tbl[3] = '{7'b1100011, 0, 0, 3, 0, 0, 1};
        tbl[4] = '{7'b0110011, 2, 0, 4, 1, 0, 3};
        tbl[5] = '{7'b0100011, 1, 2, 4, 0, 3, 2};
        tbl[6] = '{7'b0000011, 2, 1, 5, 1, 0, 5};
        tbl[7] = '{7'b1100011, 1, 0, 3, 0, 0, 2};

        rst = 1'b1;
        ready = 1'b0;
        opcode = 7'd0;
        #12;
        chk("resetVec", 32'(actVec), 32'd0);
`ifdef MCC_PERF_EN
        chk("resetRetired", retired, 32'd0);
        chk("resetStall", stall, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("firstFetch", 32'(stateOut), 32'(S_FETCH));

        for (int t = 0; t < 8; t++) runInstr(tbl[t]);
        chk("sbEmpty", sbq.size(), 32'd0);

        // Reset while a load waits on memory.
        opcode = 7'b0000011;
        ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("preRstState", 32'(stateOut), 32'(S_MREAD));
        chk("preRstRead", 32'(memRead), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstState", 32'(stateOut), 32'(S_IDLE));
        chk("rstVecAsync", 32'(actVec), 32'd0);
`ifdef MCC_PERF_EN
        chk("rstRetired", retired, 32'd0);
        chk("rstStall", stall, 32'd0);
`endif
        @(posedge clk);
        #2;
        rst = 1'b0;
        ready = 1'b1;
        chk("heldIdle", 32'(stateOut), 32'(S_IDLE));
        @(posedge clk);
        #1;
        chk("postRstFetch", 32'(stateOut), 32'(S_FETCH));
        chk("postRstRead", 32'(memRead), 32'd1);

        // Illegal opcode: halting and non-halting variants side by side.
        opcode = 7'b0010011;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("illState", 32'(stateOut), 32'(S_ILLEGAL));
        chk("illFlag", 32'(illegal), 32'd1);
        chk("illFlagZ", 32'(zIllegal), 32'd1);
        chk("illStrobes",
            32'({pcWrite, pcWriteCond, memWrite, regWrite, irWrite, memRead}),
            32'd0);
`ifdef MCC_PERF_EN
        begin
            logic [31:0] zr0;
            zr0 = zRetired;
            @(posedge clk);
            #1;
            chk("illNoRetire", zRetired - zr0, 32'd0);
        end
`else
        @(posedge clk);
        #1;
`endif
        chk("illRecoverZ", 32'(zStateOut), 32'(S_FETCH));
        chk("illClearZ", 32'(zIllegal), 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("illHold", 32'(illegal), 32'd1);
            chk("illHoldState", 32'(stateOut), 32'(S_ILLEGAL));
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
